// File: rtl/pad_cfg_pkg.sv
// Shared constants and types for the pad configuration controller.
// Register offsets, pad config width and bootsel FSM states.
package pad_cfg_pkg;

    localparam int PAD_CFG_W = 6;
    localparam int LANES     = 4;
    localparam int MAX_SLOTS = 12;

    localparam logic [11:0] OFF_SHADOW = 12'h000;
    localparam logic [11:0] OFF_COMMIT = 12'h030;
    localparam logic [11:0] OFF_STATUS = 12'h034;
    localparam logic [11:0] OFF_ACTIVE = 12'h040;

    typedef enum logic [1:0] {
        BS_SYNC,
        BS_COUNT,
        BS_LOCKED
    } bs_state_e;

endpackage

// File: rtl/pad_bootsel_latch.sv
// Bootsel synchronizer, stability counter and one-shot latch.
// Once the value has been stable long enough it is frozen until reset.
module pad_bootsel_latch
    import pad_cfg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bootsel_i,
    output logic bootsel_o,
    output logic bootsel_valid_o
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    bs_state_e       state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            val_q, val_d;
    logic            fill_q, fill_d;
    logic            bootsel_q, bootsel_d;
    logic            valid_q, valid_d;

    // State register, synchronizer chain and counter storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BS_SYNC;
            sync_q    <= '0;
            cnt_q     <= '0;
            val_q     <= 1'b0;
            fill_q    <= 1'b0;
            bootsel_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], bootsel_i};
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            fill_q    <= fill_d;
            bootsel_q <= bootsel_d;
            valid_q   <= valid_d;
        end
    end

    // Next state: wait for the synchronizer to fill, count stable samples, lock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        fill_d    = fill_q;
        bootsel_d = bootsel_q;
        valid_d   = valid_q;
        case (state_q)
            BS_SYNC: begin
                fill_d = 1'b1;
                if (fill_q) begin
                    state_d = BS_COUNT;
                end
            end
            BS_COUNT: begin
                if (sync_q[1] != val_q) begin
                    val_d = sync_q[1];
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    bootsel_d = val_q;
                    valid_d   = 1'b1;
                    state_d   = BS_LOCKED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BS_LOCKED: begin
                state_d = BS_LOCKED;
            end
            default: begin
                state_d = BS_SYNC;
            end
        endcase
    end

    assign bootsel_o       = bootsel_q;
    assign bootsel_valid_o = valid_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// APB-programmed pad configuration with shadow/active double buffering.
// Shadow writes are staged and applied to all pads at once on commit.
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int N_PADS        = 48,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                psel_i,
    input  logic                                penable_i,
    input  logic                                pwrite_i,
    input  logic [11:0]                         paddr_i,
    input  logic [31:0]                         pwdata_i,
    output logic [31:0]                         prdata_o,
    output logic                                pready_o,
    output logic                                pslverr_o,
    output logic [N_PADS-1:0][PAD_CFG_W-1:0]    pad_cfg_o,
    input  logic                                bootsel_i,
    output logic                                bootsel_o,
    output logic                                bootsel_valid_o
);

    localparam int N_SLOTS = N_PADS / LANES;
    localparam logic [9:0] W_SH = OFF_SHADOW[11:2];
    localparam logic [9:0] W_CM = OFF_COMMIT[11:2];
    localparam logic [9:0] W_ST = OFF_STATUS[11:2];
    localparam logic [9:0] W_AC = OFF_ACTIVE[11:2];

    logic [N_PADS-1:0][PAD_CFG_W-1:0] shadow_q;
    logic [N_PADS-1:0][PAD_CFG_W-1:0] active_q;
    logic        pending_q;

    logic        access;
    logic [9:0]  word;
    logic [9:0]  rel_sh;
    logic [9:0]  rel_ac;
    logic        sh_hit;
    logic        ac_hit;
    logic        cm_hit;
    logic        st_hit;
    logic [3:0]  slot;
    logic        slot_ok;
    logic        err;
    logic        sh_wr;
    logic        commit;
    logic [31:0] rdata;
    logic        unused_bits;

    assign access = psel_i & penable_i & ~rst_i;
    assign word   = paddr_i[11:2];
    assign rel_sh = word - W_SH;
    assign rel_ac = word - W_AC;
    assign sh_hit = rel_sh < 10'(MAX_SLOTS);
    assign ac_hit = rel_ac < 10'(MAX_SLOTS);
    assign cm_hit = word == W_CM;
    assign st_hit = word == W_ST;
    assign slot   = sh_hit ? rel_sh[3:0] : rel_ac[3:0];
    assign slot_ok = int'(slot) < N_SLOTS;

    // Error decode: unmapped, wrong direction, or slot beyond the pad count.
    always_comb begin
        err = 1'b0;
        if (!(sh_hit || ac_hit || cm_hit || st_hit)) begin
            err = 1'b1;
        end else if (pwrite_i && (st_hit || ac_hit)) begin
            err = 1'b1;
        end else if (!pwrite_i && cm_hit) begin
            err = 1'b1;
        end else if ((sh_hit || ac_hit) && !slot_ok) begin
            err = 1'b1;
        end
    end

    assign sh_wr  = access & pwrite_i & ~err & sh_hit;
    assign commit = access & pwrite_i & ~err & cm_hit & pwdata_i[0];

    // Shadow/active storage and the pending flag; commit wins over a set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            for (int p = 0; p < N_PADS; p++) begin
                if (sh_wr && (p / LANES) == int'(slot)) begin
                    shadow_q[p] <= pwdata_i[8*(p%LANES) +: PAD_CFG_W];
                end
            end
            if (commit) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end else if (sh_wr) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Read data mux; zero outside a successful read access.
    always_comb begin
        rdata = '0;
        if (access && !pwrite_i && !err) begin
            if (st_hit) begin
                rdata[2:0] = {bootsel_valid_o, bootsel_o, pending_q};
            end else begin
                for (int p = 0; p < N_PADS; p++) begin
                    if ((p / LANES) == int'(slot)) begin
                        rdata[8*(p%LANES) +: PAD_CFG_W] =
                            sh_hit ? shadow_q[p] : active_q[p];
                    end
                end
            end
        end
    end

    assign prdata_o  = rdata;
    assign pready_o  = access;
    assign pslverr_o = access & err;
    assign pad_cfg_o = active_q;

    assign unused_bits = ^{paddr_i[1:0], pwdata_i[31:30], pwdata_i[23:22],
                           pwdata_i[15:14], pwdata_i[7:6]};

    pad_bootsel_latch #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_bootsel (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .bootsel_i       (bootsel_i),
        .bootsel_o       (bootsel_o),
        .bootsel_valid_o (bootsel_valid_o)
    );

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: APB map, commit timing, errors,
// bootsel debounce/lock and reset abort.
module tb_pad_cfg_ctrl;

    logic             clk;
    logic             rst;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [11:0]      paddr;
    logic [31:0]      pwdata;
    logic [31:0]      prdata;
    logic             pready;
    logic             pslverr;
    logic [47:0][5:0] pad_cfg;
    logic             bootsel_in;
    logic             bootsel;
    logic             bootsel_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]      rd;
    logic             err;
    logic             rdy_acc;
    logic             rdy_setup;
    logic [47:0][5:0] pcfg_acc;

    pad_cfg_ctrl #(
        .N_PADS        (48),
        .STABLE_CYCLES (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .psel_i          (psel),
        .penable_i       (penable),
        .pwrite_i        (pwrite),
        .paddr_i         (paddr),
        .pwdata_i        (pwdata),
        .prdata_o        (prdata),
        .pready_o        (pready),
        .pslverr_o       (pslverr),
        .pad_cfg_o       (pad_cfg),
        .bootsel_i       (bootsel_in),
        .bootsel_o       (bootsel),
        .bootsel_valid_o (bootsel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [11:0] a,
                       input logic [31:0] d);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        #1 rdy_setup = pready;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rdy_acc  = pready;
        err      = pslverr;
        rd       = prdata;
        pcfg_acc = pad_cfg;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bootsel_in = 1'b1;
        psel       = 1'b1;
        penable    = 1'b1;
        pwrite     = 1'b0;
        paddr      = 12'h034;
        pwdata     = '0;

        // Reset state, with an access held during reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pads", {31'b0, |pad_cfg}, 32'd0);
        check("rst_valid", {31'b0, bootsel_valid}, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;

        // Bootsel: held 1, one-cycle glitch, then lock
        @(negedge clk);
        rst = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        bootsel_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bootsel_in = 1'b1;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1;
        check("bs_not_yet", {31'b0, bootsel_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("bs_valid", {31'b0, bootsel_valid}, 32'd1);
        check("bs_value", {31'b0, bootsel}, 32'd1);
        @(negedge clk);
        bootsel_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bs_hold_valid", {31'b0, bootsel_valid}, 32'd1);
        check("bs_hold_value", {31'b0, bootsel}, 32'd1);

        apb(1'b0, 12'h034, 32'd0);
        check("status0", rd, 32'h6);
        check("status0_rdy", {31'b0, rdy_acc}, 32'd1);
        check("setup_rdy", {31'b0, rdy_setup}, 32'd0);

        // Shadow write does not reach the pads
        apb(1'b1, 12'h000, 32'h0100_0100);
        check("sh0_err", {31'b0, err}, 32'd0);
        apb(1'b0, 12'h040, 32'd0);
        check("act0_before", rd, 32'd0);
        check("pads_untouched", {31'b0, |pad_cfg}, 32'd0);
        apb(1'b0, 12'h034, 32'd0);
        check("status_pend", rd, 32'h7);

        // Commit: pads change one cycle after the access cycle
        apb(1'b1, 12'h030, 32'd1);
        check("commit_err", {31'b0, err}, 32'd0);
        check("pad1_in_acc", {26'b0, pcfg_acc[1]}, 32'd0);
        check("pad0", {26'b0, pad_cfg[0]}, 32'h00);
        check("pad1", {26'b0, pad_cfg[1]}, 32'h01);
        check("pad2", {26'b0, pad_cfg[2]}, 32'h00);
        check("pad3", {26'b0, pad_cfg[3]}, 32'h01);
        apb(1'b0, 12'h034, 32'd0);
        check("status_clr", rd, 32'h6);

        // Reserved lane bits read as zero
        apb(1'b1, 12'h008, 32'hFFFF_FFFF);
        apb(1'b0, 12'h008, 32'd0);
        check("sh2_read", rd, 32'h3F3F_3F3F);
        check("pad8_still0", {26'b0, pad_cfg[8]}, 32'h00);

        // Error cases and no-op commit
        apb(1'b0, 12'h038, 32'd0);
        check("unmapped_err", {31'b0, err}, 32'd1);
        check("unmapped_rdy", {31'b0, rdy_acc}, 32'd1);
        apb(1'b1, 12'h040, 32'hFFFF_FFFF);
        check("wr_active_err", {31'b0, err}, 32'd1);
        apb(1'b1, 12'h030, 32'd0);
        check("commit0_err", {31'b0, err}, 32'd0);
        check("pad8_noop", {26'b0, pad_cfg[8]}, 32'h00);
        apb(1'b0, 12'h040, 32'd0);
        check("act0_after", rd, 32'h0100_0100);
        apb(1'b0, 12'h030, 32'd0);
        check("rd_commit_err", {31'b0, err}, 32'd1);
        check("rd_commit_data", rd, 32'd0);
        apb(1'b1, 12'h034, 32'd0);
        check("wr_status_err", {31'b0, err}, 32'd1);
        apb(1'b0, 12'h034, 32'd0);
        check("status_keep", rd, 32'h7);

        apb(1'b1, 12'h030, 32'd1);
        check("pad8_commit", {26'b0, pad_cfg[8]}, 32'h3F);
        check("pad11_commit", {26'b0, pad_cfg[11]}, 32'h3F);
        apb(1'b0, 12'h068, 32'd0);
        check("act10", rd, 32'd0);

        // Reset in the access cycle of a SHADOW[5] write
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h014;
        pwdata  = 32'h1515_1515;
        @(negedge clk);
        penable = 1'b1;
        rst     = 1'b1;
        #1;
        check("abort_pready", {31'b0, pready}, 32'd0);
        check("abort_pslverr", {31'b0, pslverr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_pads", {31'b0, |pad_cfg}, 32'd0);
        check("abort_valid", {31'b0, bootsel_valid}, 32'd0);
        apb(1'b0, 12'h014, 32'd0);
        check("sh5_after_rst", rd, 32'd0);
        check("sh5_err", {31'b0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
